pulsecount: RTL and testbench
=============================

PULSECOUNT -- requirements
Module: pulsecount

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the pulse counter and count output.
REQ-002 SHALL have parameter IDLE_CYCLES, default 16: number of consecutive clk cycles without a rising edge that ends a burst (legal range 2..255).
REQ-003 SHALL have parameter EXPECT, default 4: expected pulses per burst, used by the match check.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port arm, input, 1: level; sampled high in IDLE, it starts listening for a burst.
REQ-007 SHALL have port pin, input, 1: asynchronous pulse-train input (e.g. a gated clock from the board).
REQ-008 SHALL have port busy, output, 1: high in ARMED or COUNTING.
REQ-009 SHALL have port valid, output, 1: one-cycle strobe when a burst result is published.
REQ-010 SHALL have port count, output, WIDTH: latched pulse count of the last burst.
REQ-011 SHALL have port overflow, output, 1: latched; the last burst saturated the counter.
REQ-012 SHALL have port match, output, 1: latched; the last count equals EXPECT.

Function
REQ-013 SHALL pass pin through a 2-flop synchronizer, then a rise detector (sync_q & ~sync_q_d), giving a one-cycle rise strobe 3 clk cycles after pin goes high.
REQ-014 SHALL count only pulses whose high and low phases each last at least 2 clk periods; shorter pulses are unspecified.
REQ-015 SHALL implement the FSM IDLE -> ARMED (arm=1) -> COUNTING (first rise) -> DONE (idle timer expires) -> IDLE (next cycle).
REQ-016 In IDLE, rise strobes SHALL be ignored.
REQ-017 On entry to ARMED, SHALL clear the working counter.
REQ-018 On ARMED->COUNTING, SHALL set the working counter to 1.
REQ-019 Each rise in COUNTING SHALL add 1 to the working counter; at 2^WIDTH-1 it SHALL hold and set an internal sat flag.
REQ-020 The idle timer SHALL reload on every rise and decrement otherwise; reaching zero after IDLE_CYCLES cycles without a rise SHALL enter DONE.
REQ-021 In DONE, SHALL latch count, overflow=sat and match, and assert valid for exactly that cycle.
REQ-022 valid SHALL therefore rise IDLE_CYCLES+1 cycles after the last rise strobe.
REQ-023 arm=1 in ARMED or COUNTING SHALL be ignored; bursts are not restartable.
REQ-024 arm still high on return to IDLE SHALL re-arm on the next cycle (back-to-back bursts).
REQ-025 A rise in the DONE cycle SHALL be dropped.
REQ-026 count, overflow and match SHALL hold their values until the next DONE.

Reset
REQ-027 reset_n=0 at any clk edge SHALL force IDLE, clear the counter, timer and sat, and drive busy=0, valid=0, count=0, overflow=0, match=0; an in-flight burst is discarded with no valid.
REQ-028 The synchronizer flops SHALL reset to 0, so a pin already high at reset release does not count as a rise.

Configuration
REQ-029 With PULSECOUNT_MATCH_EN defined, match SHALL be computed as (count==EXPECT) and latched in DONE.
REQ-030 Without PULSECOUNT_MATCH_EN, match SHALL be constant 0, EXPECT SHALL be unused, and no comparator is built.

Structure
REQ-031 Package pulsecount_pkg SHALL hold the FSM state enum (IDLE, ARMED, COUNTING, DONE) and the default WIDTH/IDLE_CYCLES constants.
REQ-032 The synchronizer and rise detector SHALL be sub-module sync_edge (input async, output rise strobe and synced level).

Verification
REQ-033 Reset, arm, 4 pulses of 4 clk high / 4 clk low, then pin low -> one valid with count=4, match=1 (MATCH_EN), overflow=0, at 17 cycles after the 4th rise strobe.
REQ-034 WIDTH=4, 20 pulses -> count=15, overflow=1, match=0.
REQ-035 Pulses while IDLE (arm=0), then arm with no pulses for 1000 cycles -> no valid, busy stays 1.
REQ-036 reset_n=0 for 1 cycle after 2 pulses of a burst -> all outputs 0, no valid; a re-armed 3-pulse burst -> count=3.
REQ-037 arm held high, two 4-pulse bursts separated by a 40-cycle gap -> two valids, each count=4.
REQ-038 Build without PULSECOUNT_MATCH_EN, 4-pulse burst -> count=4, match=0.

Source files
------------

// File: rtl/pulsecount_pkg.sv
// pulsecount_pkg: FSM state type and default sizing shared by the pulsecount block.
package pulsecount_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_IDLE_CYCLES = 16;
   localparam int TIMER_W         = 8;   // holds IDLE_CYCLES up to 255

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COUNTING,
      DONE
   } state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous input plus a rising-edge strobe.
module sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic rise_o,
   output logic level_o
);

   logic meta_q;
   logic sync_q;
   logic sync_q_d;

   // All flops clear so a pin already high at reset release is not seen as a rise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         sync_q_d <= 1'b0;
      end else begin
         meta_q   <= async_i;
         sync_q   <= meta_q;
         sync_q_d <= sync_q;
      end
   end

   assign rise_o  = sync_q & ~sync_q_d;
   assign level_o = sync_q;

endmodule

// File: rtl/pulsecount.sv
// pulsecount: counts rising edges of an async pulse train in bursts ended by an idle timeout.
// Optional PULSECOUNT_MATCH_EN adds a latched (count == EXPECT) flag; otherwise match is 0.
module pulsecount
   import pulsecount_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int EXPECT      = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             arm,
   input  logic             pin,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] count,
   output logic             overflow,
   output logic             match
);

   localparam logic [WIDTH-1:0]   CNT_MAX    = '1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(IDLE_CYCLES);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic               done_entry;
   logic               rise;
   logic               pin_lvl_unused;

   sync_edge u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (pin),
      .rise_o  (rise),
      .level_o (pin_lvl_unused)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         timer_q <= '0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         timer_q <= timer_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
      end
   end

   // Results are latched on the edge into DONE so they are stable while valid is high.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      count_d    = count_q;
      timer_d    = timer_q;
      sat_d      = sat_q;
      ovf_d      = ovf_q;
      done_entry = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d = ARMED;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         end
         ARMED: begin
            if (rise) begin
               state_d = COUNTING;
               cnt_d   = WIDTH'(1);
               timer_d = TIMER_LOAD;
            end
         end
         COUNTING: begin
            if (rise) begin
               timer_d = TIMER_LOAD;
               if (cnt_q == CNT_MAX) sat_d = 1'b1;
               else                  cnt_d = cnt_q + WIDTH'(1);
            end else if (timer_q == TIMER_W'(1)) begin
               timer_d    = '0;
               state_d    = DONE;
               count_d    = cnt_q;
               ovf_d      = sat_q;
               done_entry = 1'b1;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == ARMED) || (state_q == COUNTING);
   assign valid    = (state_q == DONE);
   assign count    = count_q;
   assign overflow = ovf_q;

`ifdef PULSECOUNT_MATCH_EN
   logic match_q;

   always_ff @(posedge clk) begin
      if (!reset_n)        match_q <= 1'b0;
      else if (done_entry) match_q <= (cnt_q == WIDTH'(EXPECT));
   end

   assign match = match_q;
`else
   localparam int EXPECT_unused = EXPECT;
   logic done_entry_unused;

   assign done_entry_unused = done_entry;
   assign match             = 1'b0;
`endif

endmodule

// File: tb/tb_pulsecount.sv
// tb_pulsecount: directed bursts against an 8-bit and a 4-bit instance sharing one stimulus.
module tb_pulsecount;

`ifdef PULSECOUNT_MATCH_EN
   localparam logic EXP_M = 1'b1;
`else
   localparam logic EXP_M = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       arm = 1'b0;
   logic       pin = 1'b0;
   logic       busy8, valid8, ovf8, match8;
   logic [7:0] count8;
   logic       busy4, valid4, ovf4, match4;
   logic [3:0] count4;

   int         cyc = 0;
   int         rise_cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;
   int         n_valid8 = 0;
   int         n_valid4 = 0;
   int         v_cyc8 = 0;
   logic [7:0] v_count8 = '0;
   logic       v_ovf8 = 1'b0, v_match8 = 1'b0;
   logic [3:0] v_count4 = '0;
   logic       v_ovf4 = 1'b0, v_match4 = 1'b0;

   pulsecount #(.WIDTH(8), .IDLE_CYCLES(16), .EXPECT(4)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .arm(arm), .pin(pin),
      .busy(busy8), .valid(valid8), .count(count8), .overflow(ovf8), .match(match8)
   );

   pulsecount #(.WIDTH(4), .IDLE_CYCLES(16), .EXPECT(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .arm(arm), .pin(pin),
      .busy(busy4), .valid(valid4), .count(count4), .overflow(ovf4), .match(match4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid8) begin
         n_valid8 <= n_valid8 + 1;
         v_cyc8   <= cyc;
         v_count8 <= count8;
         v_ovf8   <= ovf8;
         v_match8 <= match8;
      end
      if (valid4) begin
         n_valid4 <= n_valid4 + 1;
         v_count4 <= count4;
         v_ovf4   <= ovf4;
         v_match4 <= match4;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Each pulse is 4 clk high then 4 clk low; rise_cyc marks when pin last went high.
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         pin      = 1'b1;
         rise_cyc = cyc;
         tick(4);
         pin      = 1'b0;
         tick(4);
      end
   endtask

   task automatic arm_once();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int base);
      int t;
      t = 0;
      while (n_valid8 == base && t < 200) begin
         tick(1);
         t++;
      end
      tick(3);
      chk(tag, 32'(n_valid8), 32'(base + 1));
   endtask

   initial begin
      int base;

      // reset state
      tick(3);
      reset_n = 1'b1;
      tick(1);
      chk("rst_busy",  32'(busy8),  32'(0));
      chk("rst_valid", 32'(valid8), 32'(0));
      chk("rst_count", 32'(count8), 32'(0));
      chk("rst_ovf",   32'(ovf8),   32'(0));
      chk("rst_match", 32'(match8), 32'(0));

      // basic 4-pulse burst and result latency
      base = n_valid8;
      arm_once();
      chk("a_busy", 32'(busy8), 32'(1));
      pulses(4);
      wait_valid("a_nvalid", base);
      chk("a_count",   32'(v_count8), 32'(4));
      chk("a_ovf",     32'(v_ovf8),   32'(0));
      chk("a_match",   32'(v_match8), 32'(EXP_M));
      chk("a_latency", 32'(v_cyc8 - rise_cyc - 2), 32'(17));
      chk("a_idle",    32'(busy8), 32'(0));
      chk("a_hold",    32'(count8), 32'(4));

      // 20 pulses: 4-bit instance saturates, 8-bit does not
      base = n_valid8;
      arm_once();
      pulses(20);
      wait_valid("b_nvalid", base);
      chk("b_count4", 32'(v_count4), 32'(15));
      chk("b_ovf4",   32'(v_ovf4),   32'(1));
      chk("b_match4", 32'(v_match4), 32'(0));
      chk("b_count8", 32'(v_count8), 32'(20));
      chk("b_ovf8",   32'(v_ovf8),   32'(0));

      // pulses while idle are ignored; armed with no pulses stays busy forever
      base = n_valid8;
      pulses(3);
      tick(20);
      chk("c_idle_nvalid", 32'(n_valid8), 32'(base));
      chk("c_idle_busy",   32'(busy8), 32'(0));
      arm_once();
      tick(1000);
      chk("c_armed_busy",   32'(busy8), 32'(1));
      chk("c_armed_nvalid", 32'(n_valid8), 32'(base));
      chk("c_held_count",   32'(count8), 32'(20));

      // reset mid-burst discards it
      pulses(2);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      chk("d_busy",  32'(busy8),  32'(0));
      chk("d_valid", 32'(valid8), 32'(0));
      chk("d_count", 32'(count8), 32'(0));
      chk("d_ovf",   32'(ovf8),   32'(0));
      chk("d_match", 32'(match8), 32'(0));
      chk("d_ovf4",  32'(ovf4),   32'(0));
      tick(40);
      chk("d_nvalid", 32'(n_valid8), 32'(base));
      arm_once();
      pulses(3);
      wait_valid("d2_nvalid", base);
      chk("d2_count", 32'(v_count8), 32'(3));
      chk("d2_match", 32'(v_match8), 32'(0));

      // arm held high: back-to-back bursts
      base = n_valid8;
      arm = 1'b1;
      pulses(4);
      wait_valid("e1_nvalid", base);
      chk("e1_count", 32'(v_count8), 32'(4));
      chk("e1_match", 32'(v_match8), 32'(EXP_M));
      tick(25);
      chk("e_rearmed", 32'(busy8), 32'(1));
      pulses(4);
      wait_valid("e2_nvalid", base + 1);
      chk("e2_count", 32'(v_count8), 32'(4));
      chk("e2_match", 32'(v_match8), 32'(EXP_M));
      arm = 1'b0;
      tick(25);
      chk("e_end_nvalid", 32'(n_valid8), 32'(base + 2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
